// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. It walks a pixel position (hc,vc)
// over the full raster (visible area plus porches and sync) and, on every
// pixel clock enable, registers the sync levels, display enable, pixel
// coordinates and line/frame start strobes that belong to that position.
// All outputs are registered together, so they always describe the same pixel.
//
// Optional feature macro: VGA_FRAME_COUNTER_EN
//   When defined, the FRAME_W parameter and the frame_count port exist and
//   count frames started since reset. When undefined, both are absent.
//
// Ports
//   clk_in       in   1        system/pixel clock
//   reset        in   1        synchronous, active-high reset
//   pix_ce       in   1        pixel clock enable (tie 1 when clk_in is the pixel clock)
//   h_sync       out  1        horizontal sync, active level HS_POL
//   v_sync       out  1        vertical sync, active level VS_POL
//   display_en   out  1        high while the pixel is inside the visible area
//   h_count      out  H_W      pixel column, 0..H_TOTAL-1
//   v_count      out  V_W      line, 0..V_TOTAL-1
//   line_start   out  1        one-cycle strobe on the first pixel of each line
//   frame_start  out  1        one-cycle strobe on the first pixel of each frame
//   frame_count  out  FRAME_W  frames started since reset (VGA_FRAME_COUNTER_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISPLAY = 800,
    parameter int H_FRONT   = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 64,
    parameter int V_DISPLAY = 600,
    parameter int V_FRONT   = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 23,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int H_W       = 11,
    parameter int V_W       = 10
`ifdef VGA_FRAME_COUNTER_EN
    ,
    parameter int FRAME_W   = 16
`endif
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           pix_ce,
    output logic           h_sync,
    output logic           v_sync,
    output logic           display_en,
    output logic [H_W-1:0] h_count,
    output logic [V_W-1:0] v_count,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [FRAME_W-1:0] frame_count
`endif
);

    localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEGIN   = H_DISPLAY + H_FRONT;
    localparam int HS_END     = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int VS_BEGIN   = V_DISPLAY + V_FRONT;
    localparam int VS_END     = V_DISPLAY + V_FRONT + V_SYNC;

    logic [H_W-1:0] hc;
    logic [V_W-1:0] vc;

    logic hc_last;
    logic vc_last;
    logic vis_nxt;
    logic hs_act_nxt;
    logic vs_act_nxt;
    logic line_nxt;
    logic frame_nxt;

    // Decode the current raster position. The comparisons are done on
    // zero-extended integers so that sync windows ending exactly at
    // 2**H_W or 2**V_W cannot wrap around in a narrow comparison.
    always_comb begin
        hc_last    = (int'(hc) == H_TOTAL - 1);
        vc_last    = (int'(vc) == V_TOTAL - 1);
        vis_nxt    = (int'(hc) < H_DISPLAY) && (int'(vc) < V_DISPLAY);
        hs_act_nxt = (int'(hc) >= HS_BEGIN) && (int'(hc) < HS_END);
        vs_act_nxt = (int'(vc) >= VS_BEGIN) && (int'(vc) < VS_END);
        line_nxt   = (hc == '0);
        frame_nxt  = (hc == '0) && (vc == '0);
    end

    // Raster position counters. They advance only on pixel enables and wrap
    // exactly at the last column/line so the position never leaves the raster.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_ce) begin
            if (hc_last) begin
                hc <= '0;
                if (vc_last) begin
                    vc <= '0;
                end else begin
                    vc <= vc + 1'b1;
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Output register: loads the decode of the position the counters hold
    // before they advance, giving one clock of latency for every output.
    // Level outputs hold between enables; the strobes are cleared on every
    // clock that is not an enable so they never last more than one clk_in.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            display_en  <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h_sync      <= hs_act_nxt ? HS_POL : ~HS_POL;
            v_sync      <= vs_act_nxt ? VS_POL : ~VS_POL;
            display_en  <= vis_nxt;
            h_count     <= hc;
            v_count     <= vc;
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // Frame counter steps in the same clock that frame_start is loaded,
    // so the first frame after reset already reads 1. Wraps naturally.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_count <= '0;
        end else if (pix_ce && frame_nxt) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule
